// File: rtl/apb_mem_slave.sv
// APB slave backed by a small word-addressed register memory with byte/halfword/word
// access sizes, programmable wait states and registered response outputs.
module apb_mem_slave #(
    parameter int          DEPTH       = 64,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    input  logic [1:0]  PSTRB,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic        LOAD_READY,
    output logic        store_done
);

    localparam int          IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] DEPTH_W   = 32'(DEPTH);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state_q, state_d, phase;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        write_q, write_d;
    logic        err_q, err_d;

    logic        pready_q, pready_d;
    logic        pslverr_q, pslverr_d;
    logic [31:0] prdata_q, prdata_d;
    logic        load_ready_q, load_ready_d;
    logic        store_done_q, store_done_d;

    logic [31:0] mem_q [DEPTH];
    logic [31:0] mem_d [DEPTH];

    logic [31:0]      x_addr, x_off, x_word;
    logic [1:0]       x_size;
    logic             x_write, x_err, calc_err;
    logic [IDX_W-1:0] x_idx;
    logic [31:0]      rd_word, rd_shift, rd_val, wr_shift;
    logic [3:0]       lane_mask;

    // The setup cycle is decoded from the live bus so the response register can be
    // loaded at the edge ending it; this keeps PREADY in access cycle WAIT_CYCLES+1.
    always_comb begin
        phase = state_q;
        if (state_q == IDLE && PSEL && !PENABLE) begin
            phase = SETUP;
        end
    end

    always_comb begin
        x_addr  = (phase == SETUP) ? PADDR  : addr_q;
        x_size  = (phase == SETUP) ? PSTRB  : size_q;
        x_write = (phase == SETUP) ? PWRITE : write_q;
        x_off   = x_addr - BASE_ADDR;
        x_word  = x_off >> 2;
        x_idx   = x_word[IDX_W-1:0];

        calc_err = (x_size == 2'b11)
                || (x_size == 2'b01 && x_addr[0])
                || (x_size == 2'b10 && x_addr[1:0] != 2'b00)
                || (x_addr < BASE_ADDR)
                || (x_word >= DEPTH_W);
        x_err = (phase == SETUP) ? calc_err : err_q;

        rd_word  = x_err ? 32'h0 : mem_q[x_idx];
        rd_shift = rd_word >> {x_addr[1:0], 3'b000};
        case (x_size)
            2'b00:   rd_val = {24'h0, rd_shift[7:0]};
            2'b01:   rd_val = {16'h0, rd_shift[15:0]};
            default: rd_val = rd_shift;
        endcase

        case (size_q)
            2'b00:   lane_mask = 4'b0001 << addr_q[1:0];
            2'b01:   lane_mask = 4'b0011 << {addr_q[1], 1'b0};
            default: lane_mask = 4'b1111;
        endcase
        wr_shift = wdata_q << {addr_q[1:0], 3'b000};
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        size_d       = size_q;
        write_d      = write_q;
        err_d        = err_q;
        mem_d        = mem_q;
        pready_d     = 1'b0;
        pslverr_d    = 1'b0;
        prdata_d     = 32'h0;
        load_ready_d = 1'b0;
        store_done_d = 1'b0;

        case (phase)
            SETUP: begin
                addr_d  = PADDR;
                wdata_d = PWDATA;
                size_d  = PSTRB;
                write_d = PWRITE;
                err_d   = calc_err;
                cnt_d   = WAIT_INIT;
                state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
            end
            WAIT: begin
                if (!PSEL) begin
                    cnt_d   = 4'd0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_d == 4'd0) begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                if (write_q && !err_q) begin
                    for (int b = 0; b < 4; b++) begin
                        if (lane_mask[b]) begin
                            mem_d[x_idx][8*b +: 8] = wr_shift[8*b +: 8];
                        end
                    end
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Response outputs are registered: they are loaded on the edge entering RESP.
        if (state_d == RESP) begin
            pready_d     = 1'b1;
            pslverr_d    = x_err;
            prdata_d     = (x_err || x_write) ? 32'h0 : rd_val;
            load_ready_d = !x_write && !x_err;
            store_done_d = x_write && !x_err;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            size_q       <= 2'b00;
            write_q      <= 1'b0;
            err_q        <= 1'b0;
            pready_q     <= 1'b0;
            pslverr_q    <= 1'b0;
            prdata_q     <= 32'h0;
            load_ready_q <= 1'b0;
            store_done_q <= 1'b0;
            // NOTE: the storage must read back zero after reset, so it is a reset flop array, not a RAM macro.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'h0;
            end
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            size_q       <= size_d;
            write_q      <= write_d;
            err_q        <= err_d;
            pready_q     <= pready_d;
            pslverr_q    <= pslverr_d;
            prdata_q     <= prdata_d;
            load_ready_q <= load_ready_d;
            store_done_q <= store_done_d;
            mem_q        <= mem_d;
        end
    end

    assign PREADY     = pready_q;
    assign PSLVERR    = pslverr_q;
    assign PRDATA     = prdata_q;
    assign LOAD_READY = load_ready_q;
    assign store_done = store_done_q;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Scoreboard bench for apb_mem_slave: three instances (1, 0 and 3 wait states) share
// clock and reset; the driver queues expected responses and a monitor checks them.
module tb_apb_mem_slave;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_R = 2'b11;

    typedef struct packed {
        logic        wr;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        psel [3];
    logic        penable [3];
    logic        pwrite [3];
    logic [31:0] paddr [3];
    logic [31:0] pwdata [3];
    logic [1:0]  pstrb [3];
    logic [31:0] prdata [3];
    logic        pready [3];
    logic        pslverr [3];
    logic        load_ready [3];
    logic        store_done [3];

    int   wc_of [3] = '{1, 0, 3};
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    exp_t sb0 [$];
    exp_t sb1 [$];
    exp_t sb2 [$];

    apb_mem_slave #(.DEPTH(64), .WAIT_CYCLES(1), .BASE_ADDR(32'h0000_0000)) u0 (
        .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[0]), .PENABLE(penable[0]),
        .PWRITE(pwrite[0]), .PADDR(paddr[0]), .PWDATA(pwdata[0]), .PSTRB(pstrb[0]),
        .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]),
        .LOAD_READY(load_ready[0]), .store_done(store_done[0])
    );

    apb_mem_slave #(.DEPTH(16), .WAIT_CYCLES(0), .BASE_ADDR(32'h0000_0100)) u1 (
        .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[1]), .PENABLE(penable[1]),
        .PWRITE(pwrite[1]), .PADDR(paddr[1]), .PWDATA(pwdata[1]), .PSTRB(pstrb[1]),
        .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]),
        .LOAD_READY(load_ready[1]), .store_done(store_done[1])
    );

    apb_mem_slave #(.DEPTH(64), .WAIT_CYCLES(3), .BASE_ADDR(32'h0000_0000)) u2 (
        .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[2]), .PENABLE(penable[2]),
        .PWRITE(pwrite[2]), .PADDR(paddr[2]), .PWDATA(pwdata[2]), .PSTRB(pstrb[2]),
        .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2]),
        .LOAD_READY(load_ready[2]), .store_done(store_done[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic void sb_push(input int d, input exp_t e);
        case (d)
            0:       sb0.push_back(e);
            1:       sb1.push_back(e);
            default: sb2.push_back(e);
        endcase
    endfunction

    function automatic int sb_size(input int d);
        case (d)
            0:       return sb0.size();
            1:       return sb1.size();
            default: return sb2.size();
        endcase
    endfunction

    function automatic exp_t sb_pop(input int d);
        case (d)
            0:       return sb0.pop_front();
            1:       return sb1.pop_front();
            default: return sb2.pop_front();
        endcase
    endfunction

    // Called just after a rising edge; returns just after the edge ending the access.
    task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                        input logic [1:0] size, input logic [31:0] wdata,
                        input logic exp_err, input logic [31:0] exp_rd);
        exp_t e;
        int   n;
        e.wr    = wr;
        e.err   = exp_err;
        e.rdata = (wr || exp_err) ? 32'h0 : exp_rd;
        sb_push(d, e);
        psel[d]    = 1'b1;
        penable[d] = 1'b0;
        pwrite[d]  = wr;
        paddr[d]   = addr;
        pstrb[d]   = size;
        pwdata[d]  = wdata;
        @(posedge clk); #1;
        penable[d] = 1'b1;
        n = 0;
        for (int c = 1; c <= 32; c++) begin
            @(negedge clk);
            if (pready[d]) begin
                n = c;
                break;
            end
            @(posedge clk); #1;
        end
        check($sformatf("u%0d_pready_cycle_%h", d, addr), 64'(n), 64'(wc_of[d] + 1));
        @(posedge clk); #1;
        psel[d]    = 1'b0;
        penable[d] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (pready[d]) begin
                    if (sb_size(d) == 0) begin
                        check($sformatf("u%0d_unexpected_pready", d), 64'd1, 64'd0);
                    end else begin
                        e = sb_pop(d);
                        check($sformatf("u%0d_pslverr", d), 64'(pslverr[d]), 64'(e.err));
                        check($sformatf("u%0d_prdata", d), 64'(prdata[d]), 64'(e.rdata));
                        check($sformatf("u%0d_load_ready", d), 64'(load_ready[d]), 64'(!e.wr && !e.err));
                        check($sformatf("u%0d_store_done", d), 64'(store_done[d]), 64'(e.wr && !e.err));
                    end
                end else begin
                    check($sformatf("u%0d_idle_outputs_zero", d),
                          64'({pslverr[d], load_ready[d], store_done[d], prdata[d]}), 64'd0);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
            paddr[d] = 32'h0; pwdata[d] = 32'h0; pstrb[d] = SZ_W;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("u%0d_reset_outputs", d),
                  64'({pready[d], pslverr[d], load_ready[d], store_done[d], prdata[d]}), 64'd0);
        end
        rst_n = 1'b1;

        // Wait-state 1 instance: word, byte and halfword accesses plus error cases.
        xfer(0, 1'b1, 32'h08, SZ_W, 32'hDEAD_BEEF, 1'b0, 32'h0);
        xfer(0, 1'b0, 32'h08, SZ_W, 32'h0,         1'b0, 32'hDEAD_BEEF);
        idle(1);
        xfer(0, 1'b1, 32'h08, SZ_W, 32'h1122_3344, 1'b0, 32'h0);
        xfer(0, 1'b1, 32'h09, SZ_B, 32'h0000_0055, 1'b0, 32'h0);
        xfer(0, 1'b0, 32'h08, SZ_W, 32'h0,         1'b0, 32'h1122_5544);
        xfer(0, 1'b0, 32'h0A, SZ_H, 32'h0,         1'b0, 32'h0000_1122);
        xfer(0, 1'b0, 32'h0B, SZ_B, 32'h0,         1'b0, 32'h0000_0011);
        xfer(0, 1'b1, 32'h03, SZ_H, 32'h0000_FFFF, 1'b1, 32'h0);
        xfer(0, 1'b0, 32'h06, SZ_W, 32'h0,         1'b1, 32'h0);
        xfer(0, 1'b1, 32'h08, SZ_R, 32'hFFFF_FFFF, 1'b1, 32'h0);
        xfer(0, 1'b0, 32'h100, SZ_W, 32'h0,        1'b1, 32'h0);
        xfer(0, 1'b1, 32'h100, SZ_W, 32'h0000_0001, 1'b1, 32'h0);
        xfer(0, 1'b0, 32'h08, SZ_W, 32'h0,         1'b0, 32'h1122_5544);
        xfer(0, 1'b0, 32'h00, SZ_W, 32'h0,         1'b0, 32'h0);
        xfer(0, 1'b1, 32'hFC, SZ_W, 32'hA5A5_A5A5, 1'b0, 32'h0);
        xfer(0, 1'b0, 32'hFC, SZ_W, 32'h0,         1'b0, 32'hA5A5_A5A5);
        xfer(0, 1'b1, 32'h0E, SZ_H, 32'h0000_BEEF, 1'b0, 32'h0);
        xfer(0, 1'b0, 32'h0C, SZ_W, 32'h0,         1'b0, 32'hBEEF_0000);

        // Zero-wait instance at base 0x100: PENABLE without setup must be ignored.
        psel[1] = 1'b1; penable[1] = 1'b1; pwrite[1] = 1'b1;
        paddr[1] = 32'h104; pstrb[1] = SZ_W; pwdata[1] = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        #1;
        check("u1_no_setup_no_pready", 64'(pready[1]), 64'd0);
        psel[1] = 1'b0; penable[1] = 1'b0;
        idle(1);
        xfer(1, 1'b0, 32'h104, SZ_W, 32'h0,         1'b0, 32'h0);
        xfer(1, 1'b1, 32'h104, SZ_W, 32'h1234_5678, 1'b0, 32'h0);
        xfer(1, 1'b0, 32'h104, SZ_W, 32'h0,         1'b0, 32'h1234_5678);
        xfer(1, 1'b1, 32'h107, SZ_B, 32'h0000_00AB, 1'b0, 32'h0);
        xfer(1, 1'b0, 32'h104, SZ_W, 32'h0,         1'b0, 32'hAB34_5678);
        xfer(1, 1'b0, 32'h0FC, SZ_W, 32'h0,         1'b1, 32'h0);
        xfer(1, 1'b0, 32'h140, SZ_W, 32'h0,         1'b1, 32'h0);
        xfer(1, 1'b0, 32'h13C, SZ_W, 32'h0,         1'b0, 32'h0);
        xfer(1, 1'b0, 32'h106, SZ_H, 32'h0,         1'b0, 32'h0000_AB34);

        // Three-wait instance: abort a write during WAIT; the old word must survive.
        xfer(2, 1'b1, 32'h20, SZ_W, 32'h0102_0304, 1'b0, 32'h0);
        psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1;
        paddr[2] = 32'h20; pstrb[2] = SZ_W; pwdata[2] = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        penable[2] = 1'b1;
        @(posedge clk); #1;
        psel[2] = 1'b0; penable[2] = 1'b0;
        idle(4);
        xfer(2, 1'b0, 32'h20, SZ_W, 32'h0, 1'b0, 32'h0102_0304);

        // Reset while u0 is presenting read data and u2 is mid-write.
        idle(1);
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b0; paddr[0] = 32'h08; pstrb[0] = SZ_W;
        psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1; paddr[2] = 32'h10; pstrb[2] = SZ_W;
        pwdata[2] = 32'hCAFE_F00D;
        @(posedge clk); #1;
        penable[0] = 1'b1; penable[2] = 1'b1;
        @(posedge clk); #1;
        check("rst_pre_u0_pready", 64'(pready[0]), 64'd1);
        check("rst_pre_u0_prdata", 64'(prdata[0]), 64'h1122_5544);
        check("rst_pre_u0_load_ready", 64'(load_ready[0]), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_async_u0_outputs",
              64'({pready[0], load_ready[0], store_done[0], prdata[0]}), 64'd0);
        for (int d = 0; d < 3; d++) begin
            psel[d] = 1'b0; penable[d] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 64; i++) begin
            xfer(2, 1'b0, 32'(i * 4), SZ_W, 32'h0, 1'b0, 32'h0);
        end
        xfer(0, 1'b0, 32'h08,  SZ_W, 32'h0, 1'b0, 32'h0);
        xfer(0, 1'b0, 32'hFC,  SZ_W, 32'h0, 1'b0, 32'h0);
        xfer(1, 1'b0, 32'h104, SZ_W, 32'h0, 1'b0, 32'h0);

        idle(3);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("u%0d_scoreboard_drained", d), 64'(sb_size(d)), 64'd0);
        end
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
